usr_param_burst: RTL and testbench

//  Parametrised next-generation universal shift register: WIDTH-bit register with hold,

---
 rtl/usr_param_burst_pkg.sv | 22 ++
 rtl/usr_param_burst_ctrl.sv | 80 ++++++++
 rtl/usr_param_burst.sv | 99 +++++++++
 tb/tb_usr_param_burst.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/usr_param_burst_pkg.sv
// Shared types for the universal shift register with burst sequencer.
//   usr_op_e    : operation select encoding used on the op port
//   usr_state_e : burst sequencer state
package usr_pkg;

  typedef enum logic [2:0] {
    HOLD  = 3'd0,
    SHR   = 3'd1,
    SHL   = 3'd2,
    LOAD  = 3'd3,
    ROR   = 3'd4,
    ROL   = 3'd5,
    ASR   = 3'd6,
    BURST = 3'd7
  } usr_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } usr_state_e;

endpackage

// File: rtl/usr_param_burst_ctrl.sv
// Burst shift sequencer: IDLE/RUN FSM plus down-counter.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   start         : accepted BURST request (en & !busy & op==BURST)
//   amt           : requested shift count, saturated to WIDTH
//   dir           : burst direction captured at start (0=right, 1=left)
//   busy          : burst in progress
//   done          : one-cycle pulse when a burst finishes (or amt==0 accepted)
//   shift_strobe  : shift the data register this edge
//   shift_dir     : direction captured at start
module usr_burst_ctrl
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] amt,
  input  logic          dir,
  output logic          busy,
  output logic          done,
  output logic          shift_strobe,
  output logic          shift_dir
);

  usr_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_d;
  logic          dir_q, dir_d;
  logic [CW-1:0] amt_sat;

  assign amt_sat = (amt > CW'(WIDTH)) ? CW'(WIDTH) : amt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done    <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done    <= done_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    dir_d   = dir_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d = amt_sat;
          dir_d = dir;
          // A zero-length burst completes immediately without ever going busy.
          if (amt_sat == '0) done_d = 1'b1;
          else               state_d = RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy         = (state_q == RUN);
  assign shift_strobe = (state_q == RUN);
  assign shift_dir    = dir_q;

endmodule

// File: rtl/usr_param_burst.sv
// Universal shift register with hold, serial shift L/R, parallel load,
// rotate, arithmetic shift and an autonomous multi-cycle burst shift.
// Optional feature macro: USR_PARITY_EN (registered XOR-reduce of q on parity;
// when undefined parity is tied low).
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   en, op        : operation strobe/select (sampled only when not busy)
//   b             : parallel load data
//   r_in, l_in    : serial fill for right / left shifts
//   amt, dir      : burst count and direction (0=right, 1=left)
//   q             : register contents
//   so_r, so_l    : q[0], q[WIDTH-1]
//   busy, done    : burst in progress / one-cycle burst-finished pulse
//   parity        : ^q when USR_PARITY_EN, else 0
module usr_param_burst
  import usr_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] b,
  input  logic             r_in,
  input  logic             l_in,
  input  logic [CW-1:0]    amt,
  input  logic             dir,
  output logic [WIDTH-1:0] q,
  output logic             so_r,
  output logic             so_l,
  output logic             busy,
  output logic             done,
  output logic             parity
);

  logic [WIDTH-1:0] q_next;
  logic             start;
  logic             shift_strobe;
  logic             shift_dir;

  assign start = en && !busy && (usr_op_e'(op) == BURST);

  usr_burst_ctrl #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_ctrl (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .amt          (amt),
    .dir          (dir),
    .busy         (busy),
    .done         (done),
    .shift_strobe (shift_strobe),
    .shift_dir    (shift_dir)
  );

  always_comb begin
    q_next = q;
    if (shift_strobe) begin
      // Serial inputs are sampled live on every burst shift.
      if (shift_dir) q_next = {q[WIDTH-2:0], l_in};
      else           q_next = {r_in, q[WIDTH-1:1]};
    end else if (en) begin
      case (usr_op_e'(op))
        HOLD:    q_next = q;
        SHR:     q_next = {r_in, q[WIDTH-1:1]};
        SHL:     q_next = {q[WIDTH-2:0], l_in};
        LOAD:    q_next = b;
        ROR:     q_next = {q[0], q[WIDTH-1:1]};
        ROL:     q_next = {q[WIDTH-2:0], q[WIDTH-1]};
        ASR:     q_next = {q[WIDTH-1], q[WIDTH-1:1]};
        BURST:   q_next = q;
        default: q_next = q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else     q <= q_next;
  end

`ifdef USR_PARITY_EN
  // Registered from q_next so parity always matches the current q.
  always_ff @(posedge clk) begin
    if (rst) parity <= 1'b0;
    else     parity <= ^q_next;
  end
`else
  assign parity = 1'b0;
`endif

  assign so_r = q[0];
  assign so_l = q[WIDTH-1];

endmodule

// File: tb/tb_usr_param_burst.sv
module tb_usr_param_burst;

  logic       clk = 1'b0;
  logic       rst, en, r_in, l_in, dir;
  logic [2:0] op;
  logic [7:0] b;
  logic [3:0] amt;
  logic [7:0] q;
  logic       so_r, so_l, busy, done, parity;

`ifdef USR_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  bit checking = 1'b0;

  usr_param_burst #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .en(en), .op(op), .b(b), .r_in(r_in), .l_in(l_in),
    .amt(amt), .dir(dir), .q(q), .so_r(so_r), .so_l(so_l), .busy(busy),
    .done(done), .parity(parity)
  );

  always #5 clk = ~clk;

  // Reference model: integer arithmetic on the register value, remaining burst length.
  int m_q   = 0;
  int m_rem = 0;
  int m_dir = 0;
  int m_done = 0;

  function automatic int red_xor(input int v);
    int p = 0;
    for (int i = 0; i < 8; i++) p ^= (v >> i) & 1;
    return p;
  endfunction

  always @(posedge clk) begin
    int n;
    if (rst) begin
      m_q = 0; m_rem = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (m_rem > 0) begin
        if (m_dir != 0) m_q = ((m_q * 2) + int'(l_in)) % 256;
        else            m_q = (m_q / 2) + 128 * int'(r_in);
        m_rem = m_rem - 1;
        if (m_rem == 0) m_done = 1;
      end else if (en) begin
        case (int'(op))
          1: m_q = (m_q / 2) + 128 * int'(r_in);
          2: m_q = ((m_q * 2) + int'(l_in)) % 256;
          3: m_q = int'(b);
          4: m_q = (m_q / 2) + 128 * (m_q % 2);
          5: m_q = ((m_q * 2) % 256) + (m_q / 128);
          6: m_q = (m_q / 2) + (m_q / 128) * 128;
          7: begin
            n = (int'(amt) > 8) ? 8 : int'(amt);
            if (n == 0) m_done = 1;
            else begin m_rem = n; m_dir = int'(dir); end
          end
          default: ;
        endcase
      end
    end
  end

  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      cmp("q", int'(q), m_q);
      cmp("so_r", int'(so_r), m_q % 2);
      cmp("so_l", int'(so_l), m_q / 128);
      cmp("busy", int'(busy), (m_rem > 0) ? 1 : 0);
      cmp("done", int'(done), m_done);
      cmp("parity", int'(parity), PAR_ON ? red_xor(m_q) : 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [2:0] o, input logic [7:0] bb);
    en = 1'b1; op = o; b = bb;
    tick();
    en = 1'b0; op = 3'd0;
  endtask

  // Starts a burst, then keeps presenting a conflicting LOAD while busy.
  task automatic run_burst(input logic [3:0] a, input logic d,
                           output int nbusy, output int donehi);
    en = 1'b1; op = 3'd7; amt = a; dir = d;
    tick();
    nbusy = 0;
    while (busy && nbusy < 40) begin
      en = 1'b1; op = 3'd3; b = 8'hFF; amt = 4'd2; dir = ~d;
      tick();
      nbusy++;
    end
    en = 1'b0; op = 3'd0;
    donehi = int'(done);
  endtask

  initial begin
    int nb, dh;
    rst = 1'b1; en = 1'b0; op = 3'd0; b = 8'h00; r_in = 1'b0; l_in = 1'b0;
    amt = 4'd0; dir = 1'b0;
    tick();
    rst = 1'b0;
    checking = 1'b1;

    // 1: reset after random contents
    do_op(3'd3, 8'($urandom_range(1, 255)));
    rst = 1'b1; tick(); rst = 1'b0;
    cmp("rst_q", int'(q), 8'h00);
    cmp("rst_busy", int'(busy), 0);
    cmp("rst_done", int'(done), 0);
    cmp("rst_parity", int'(parity), 0);

    // 2: single-cycle ops
    do_op(3'd3, 8'hA5);
    r_in = 1'b1; do_op(3'd1, 8'h00); r_in = 1'b0;
    cmp("shr", int'(q), 8'hD2);
    l_in = 1'b0; do_op(3'd2, 8'h00);
    cmp("shl", int'(q), 8'hA4);
    do_op(3'd5, 8'h00);
    cmp("rol", int'(q), 8'h49);
    do_op(3'd3, 8'h80);
    do_op(3'd6, 8'h00);
    cmp("asr", int'(q), 8'hC0);
    do_op(3'd3, 8'h01);
    do_op(3'd4, 8'h00);
    cmp("ror", int'(q), 8'h80);
    en = 1'b0; op = 3'd3; b = 8'h55; tick(); op = 3'd0;
    cmp("en0_hold", int'(q), 8'h80);

    // 3: burst right by 3, ops ignored while busy, new op accepted with done
    do_op(3'd3, 8'h81);
    r_in = 1'b0;
    run_burst(4'd3, 1'b0, nb, dh);
    cmp("b3_busy_cycles", nb, 3);
    cmp("b3_q", int'(q), 8'h10);
    cmp("b3_done", dh, 1);
    do_op(3'd3, 8'h3C);
    cmp("op_on_done", int'(q), 8'h3C);
    cmp("done_clear", int'(done), 0);

    // 4: zero-length burst, then saturating burst left
    do_op(3'd3, 8'h10);
    en = 1'b1; op = 3'd7; amt = 4'd0; dir = 1'b0; tick(); en = 1'b0; op = 3'd0;
    cmp("b0_busy", int'(busy), 0);
    cmp("b0_done", int'(done), 1);
    cmp("b0_q", int'(q), 8'h10);
    tick();
    cmp("b0_done_once", int'(done), 0);
    l_in = 1'b1;
    run_burst(4'd15, 1'b1, nb, dh);
    l_in = 1'b0;
    cmp("b15_busy_cycles", nb, 8);
    cmp("b15_q", int'(q), 8'hFF);
    cmp("b15_done", dh, 1);

    // 5: reset aborts a running burst
    do_op(3'd3, 8'hF0);
    r_in = 1'b1;
    en = 1'b1; op = 3'd7; amt = 4'd6; dir = 1'b0; tick(); en = 1'b0; op = 3'd0;
    tick(); tick();
    cmp("b6_mid_q", int'(q), 8'hFC);
    cmp("b6_mid_busy", int'(busy), 1);
    rst = 1'b1; tick(); rst = 1'b0; r_in = 1'b0;
    cmp("abort_q", int'(q), 8'h00);
    cmp("abort_busy", int'(busy), 0);
    for (int i = 0; i < 6; i++) begin
      cmp("abort_no_done", int'(done), 0);
      tick();
    end

    // 6: parity
    do_op(3'd3, 8'h07);
    cmp("par_07", int'(parity), PAR_ON ? 1 : 0);
    do_op(3'd2, 8'h00);
    cmp("shl_0e", int'(q), 8'h0E);
    cmp("par_0e", int'(parity), PAR_ON ? 1 : 0);
    do_op(3'd3, 8'h03);
    cmp("par_03", int'(parity), 0);

    tick();
    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
